// File: rtl/crc_pkg.sv
// Shared types and constants for the CRC engine.
//   crc_state_t : engine FSM encoding (IDLE / SHIFT / EMIT)
//   CRC_A_* / CRC_B_* : ISO 14443 CRC_A and CRC_B parameter sets
//                       (reflected polynomial x^16+x^12+x^5+1)
package crc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_EMIT  = 2'd2
  } crc_state_t;

  localparam logic [15:0] CRC_A_POLY_REFL = 16'h8408;
  localparam logic [15:0] CRC_A_INIT      = 16'h6363;
  localparam logic [15:0] CRC_B_INIT      = 16'hFFFF;
  localparam logic [15:0] CRC_B_XOROUT    = 16'hFFFF;
  localparam logic [15:0] CRC_A_RESIDUE   = 16'h0000;
  localparam logic [15:0] CRC_B_RESIDUE   = 16'hF0B8;

endpackage

// File: rtl/crc_lfsr_step.sv
// Combinational reflected-CRC step: advances the register by
// BITS_PER_CYCLE input bits, bits[0] first.
//   cur  : current register value
//   bits : input bits for this step, LSb consumed first
//   nxt  : register after BITS_PER_CYCLE single-bit updates
module crc_lfsr_step #(
  parameter int unsigned       WIDTH          = 16,
  parameter logic [WIDTH-1:0]  POLY_REFL      = WIDTH'(16'h8408),
  parameter int unsigned       BITS_PER_CYCLE = 1
) (
  input  logic [WIDTH-1:0]          cur,
  input  logic [BITS_PER_CYCLE-1:0] bits,
  output logic [WIDTH-1:0]          nxt
);

  always_comb begin
    nxt = cur;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      if (nxt[0] ^ bits[i]) nxt = (nxt >> 1) ^ POLY_REFL;
      else                  nxt = nxt >> 1;
    end
  end

endmodule

// File: rtl/crc_engine.sv
// Byte-fed reflected CRC engine (CRC_A / CRC_B and similar), up to 32 bits,
// consuming BITS_PER_CYCLE bits per clock, with optional LSByte-first
// emission of the finished CRC.
//   clk, rst           : clock, synchronous active-high reset
//   start              : reload INIT and abort any operation
//   in_valid/in_ready/in_data    : byte input handshake, LSb first
//   append_req         : begin emitting the CRC bytes (IDLE only)
//   out_valid/out_ready/out_data : emitted CRC byte stream
//   crc                : register ^ XOROUT
//   busy               : engine not idle
//   crc_ok             : residue match; active only when CRC_ENGINE_CHECK_EN
//                        is defined, otherwise tied low
module crc_engine
  import crc_pkg::*;
#(
  parameter int unsigned      WIDTH          = 16,
  parameter logic [WIDTH-1:0] POLY_REFL      = WIDTH'(16'h8408),
  parameter logic [WIDTH-1:0] INIT           = WIDTH'(16'h6363),
  parameter logic [WIDTH-1:0] XOROUT         = WIDTH'(16'h0000),
  parameter logic [WIDTH-1:0] RESIDUE        = WIDTH'(16'h0000),
  parameter int unsigned      BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             append_req,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic [WIDTH-1:0] crc,
  output logic             busy,
  output logic             crc_ok
);

  localparam int unsigned STEPS    = 8 / BITS_PER_CYCLE;
  localparam logic [1:0]  LAST_IDX = 2'(WIDTH / 8 - 1);

  crc_state_t              state_q;
  logic [WIDTH-1:0]        reg_q;
  logic [WIDTH-1:0]        step_nxt;
  logic [7:0]              data_q;
  logic [2:0]              cnt_q;
  logic [1:0]              idx_q;
  logic                    accept;
  logic                    append_go;
  logic [BITS_PER_CYCLE-1:0] step_bits;

  assign in_ready  = (state_q == ST_IDLE) && !start;
  assign accept    = in_ready && in_valid;
  assign append_go = (state_q == ST_IDLE) && append_req && !start && !accept;

  // The first slice of an accepted byte is taken straight from in_data so the
  // byte starts shifting on its accept edge; later slices come from the latch.
  assign step_bits = accept ? in_data[BITS_PER_CYCLE-1:0]
                            : data_q[BITS_PER_CYCLE-1:0];

  crc_lfsr_step #(
    .WIDTH          (WIDTH),
    .POLY_REFL      (POLY_REFL),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_step (
    .cur  (reg_q),
    .bits (step_bits),
    .nxt  (step_nxt)
  );

  assign crc       = reg_q ^ XOROUT;
  assign out_valid = (state_q == ST_EMIT);
  assign out_data  = 8'(crc >> {idx_q, 3'b000});
  assign busy      = (state_q != ST_IDLE);

`ifdef CRC_ENGINE_CHECK_EN
  assign crc_ok = (state_q == ST_IDLE) && (reg_q == RESIDUE);
`else
  logic unused_residue;
  assign unused_residue = ^RESIDUE;
  assign crc_ok = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst || start) begin
      state_q <= ST_IDLE;
      reg_q   <= INIT;
      data_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            reg_q  <= step_nxt;
            data_q <= in_data >> BITS_PER_CYCLE;
            if (STEPS > 1) begin
              cnt_q   <= 3'(STEPS - 2);
              state_q <= ST_SHIFT;
            end
          end else if (append_go) begin
            idx_q   <= '0;
            state_q <= ST_EMIT;
          end
        end
        ST_SHIFT: begin
          reg_q  <= step_nxt;
          data_q <= data_q >> BITS_PER_CYCLE;
          if (cnt_q == '0) state_q <= ST_IDLE;
          else             cnt_q   <= cnt_q - 3'd1;
        end
        ST_EMIT: begin
          if (out_ready) begin
            if (idx_q == LAST_IDX) begin
              idx_q   <= '0;
              state_q <= ST_IDLE;
            end else begin
              idx_q <= idx_q + 2'd1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crc_engine.sv
// Testbench for crc_engine: four CRC_A instances (1/2/4/8 bits per cycle)
// and one CRC_B instance (4 bits per cycle), driven independently.
// crc_ok expectations follow CRC_ENGINE_CHECK_EN.
module tb_crc_engine;
  import crc_pkg::*;

  localparam int N = 5;
`ifdef CRC_ENGINE_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start      [N];
  logic        in_valid   [N];
  logic        in_ready   [N];
  logic [7:0]  in_data    [N];
  logic        append_req [N];
  logic        out_valid  [N];
  logic        out_ready  [N];
  logic [7:0]  out_data   [N];
  logic [15:0] crc        [N];
  logic        busy       [N];
  logic        crc_ok     [N];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int unsigned BPC = (g == 4) ? 4 : (1 << g);
    localparam logic [15:0] INI = (g == 4) ? CRC_B_INIT : CRC_A_INIT;
    localparam logic [15:0] XO  = (g == 4) ? CRC_B_XOROUT : 16'h0000;
    localparam logic [15:0] RES = (g == 4) ? CRC_B_RESIDUE : CRC_A_RESIDUE;
    crc_engine #(
      .WIDTH          (16),
      .POLY_REFL      (CRC_A_POLY_REFL),
      .INIT           (INI),
      .XOROUT         (XO),
      .RESIDUE        (RES),
      .BITS_PER_CYCLE (BPC)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start[g]),
      .in_valid   (in_valid[g]),
      .in_ready   (in_ready[g]),
      .in_data    (in_data[g]),
      .append_req (append_req[g]),
      .out_valid  (out_valid[g]),
      .out_ready  (out_ready[g]),
      .out_data   (out_data[g]),
      .crc        (crc[g]),
      .busy       (busy[g]),
      .crc_ok     (crc_ok[g])
    );
  end

  typedef struct packed {
    logic        is_b;
    logic [2:0]  n;
    logic [47:0] data;    // byte k in bits [8k+7:8k]
    logic [15:0] exp_crc;
    logic        exp_ok;  // expected crc_ok when the check is built in
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int d);
    start[d] = 1'b1;
    sync();
    start[d] = 1'b0;
  endtask

  task automatic send_byte(input int d, input logic [7:0] b);
    logic done;
    done = 1'b0;
    in_valid[d] = 1'b1;
    in_data[d]  = b;
    for (int t = 0; t < 40 && !done; t++) begin
      @(negedge clk);
      if (in_ready[d]) done = 1'b1;
      sync();
    end
    in_valid[d] = 1'b0;
    if (!done) check($sformatf("accept_timeout_inst%0d", d), 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input int d);
    logic done;
    done = 1'b0;
    for (int t = 0; t < 40 && !done; t++) begin
      @(negedge clk);
      if (!busy[d]) done = 1'b1;
    end
    if (!done) check($sformatf("idle_timeout_inst%0d", d), 32'd0, 32'd1);
    sync();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int lo, hi;
    rst = 1'b1;
    for (int d = 0; d < N; d++) begin
      start[d] = 1'b0; in_valid[d] = 1'b0; in_data[d] = 8'h00;
      append_req[d] = 1'b0; out_ready[d] = 1'b0;
    end

    tbl[0] = '{1'b0, 3'd0, 48'h0,            16'h6363, 1'b0};
    tbl[1] = '{1'b0, 3'd2, 48'h0000,         16'h1EA0, 1'b0};
    tbl[2] = '{1'b0, 3'd2, 48'h3412,         16'hCF26, 1'b0};
    tbl[3] = '{1'b0, 3'd4, 48'hCF263412,     16'h0000, 1'b1};
    tbl[4] = '{1'b0, 3'd4, 48'hCE263412,     16'h1189, 1'b0};
    tbl[5] = '{1'b1, 3'd3, 48'h000000,       16'hC6CC, 1'b0};
    tbl[6] = '{1'b1, 3'd3, 48'hFFAA0F,       16'hD1FC, 1'b0};
    tbl[7] = '{1'b1, 3'd5, 48'hD1FCFFAA0F,   16'h0F47, 1'b1};

    repeat (2) sync();
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < N; d++) begin
      check($sformatf("rst_crc_inst%0d", d), 32'(crc[d]), (d == 4) ? 32'h0000 : 32'h6363);
      check($sformatf("rst_out_data_inst%0d", d), 32'(out_data[d]), (d == 4) ? 32'h00 : 32'h63);
      check($sformatf("rst_in_ready_inst%0d", d), 32'(in_ready[d]), 32'd1);
      check($sformatf("rst_out_valid_inst%0d", d), 32'(out_valid[d]), 32'd0);
      check($sformatf("rst_busy_inst%0d", d), 32'(busy[d]), 32'd0);
    end
    sync();

    // Table vectors
    for (int i = 0; i < 8; i++) begin
      lo = tbl[i].is_b ? 4 : 0;
      hi = tbl[i].is_b ? 4 : 3;
      for (int d = lo; d <= hi; d++) begin
        do_start(d);
        for (int k = 0; k < int'(tbl[i].n); k++) send_byte(d, tbl[i].data[8*k +: 8]);
        wait_idle(d);
        @(negedge clk);
        check($sformatf("vec%0d_crc_inst%0d", i, d), 32'(crc[d]), 32'(tbl[i].exp_crc));
        check($sformatf("vec%0d_ok_inst%0d", i, d), 32'(crc_ok[d]), 32'(tbl[i].exp_ok & CHK));
        sync();
      end
    end

    // Emission with out_ready toggling (BITS_PER_CYCLE=1)
    do_start(0);
    send_byte(0, 8'h12);
    send_byte(0, 8'h34);
    wait_idle(0);
    append_req[0] = 1'b1;
    sync();
    append_req[0] = 1'b0;
    out_ready[0]  = 1'b0;
    @(negedge clk);
    check("emit0_valid", 32'(out_valid[0]), 32'd1);
    check("emit0_data", 32'(out_data[0]), 32'h26);
    check("emit0_busy", 32'(busy[0]), 32'd1);
    check("emit0_in_ready", 32'(in_ready[0]), 32'd0);
    sync();
    out_ready[0] = 1'b1;
    @(negedge clk);
    check("emit0_hold_valid", 32'(out_valid[0]), 32'd1);
    check("emit0_hold_data", 32'(out_data[0]), 32'h26);
    sync();
    out_ready[0] = 1'b0;
    @(negedge clk);
    check("emit1_valid", 32'(out_valid[0]), 32'd1);
    check("emit1_data", 32'(out_data[0]), 32'hCF);
    sync();
    out_ready[0] = 1'b1;
    @(negedge clk);
    check("emit1_hold_data", 32'(out_data[0]), 32'hCF);
    sync();
    out_ready[0] = 1'b0;
    @(negedge clk);
    check("emit_done_busy", 32'(busy[0]), 32'd0);
    check("emit_done_valid", 32'(out_valid[0]), 32'd0);
    check("emit_done_crc", 32'(crc[0]), 32'hCF26);
    sync();

    // start on the 4th SHIFT cycle of byte 12, in_valid held high
    do_start(0);
    in_valid[0] = 1'b1;
    in_data[0]  = 8'h12;
    @(negedge clk);
    check("abort_accept_ready", 32'(in_ready[0]), 32'd1);
    sync();
    repeat (3) sync();
    start[0] = 1'b1;
    @(negedge clk);
    check("abort_in_ready_low", 32'(in_ready[0]), 32'd0);
    check("abort_busy_before", 32'(busy[0]), 32'd1);
    sync();
    start[0]    = 1'b0;
    in_valid[0] = 1'b0;
    @(negedge clk);
    check("abort_crc", 32'(crc[0]), 32'h6363);
    check("abort_busy", 32'(busy[0]), 32'd0);
    sync();
    send_byte(0, 8'h00);
    send_byte(0, 8'h00);
    wait_idle(0);
    @(negedge clk);
    check("abort_then_0000", 32'(crc[0]), 32'h1EA0);
    sync();

    // rst during EMIT after the first byte transfer
    do_start(0);
    send_byte(0, 8'h12);
    send_byte(0, 8'h34);
    wait_idle(0);
    append_req[0] = 1'b1;
    sync();
    append_req[0] = 1'b0;
    out_ready[0]  = 1'b1;
    sync();
    out_ready[0] = 1'b0;
    @(negedge clk);
    check("rst_emit_mid_data", 32'(out_data[0]), 32'hCF);
    sync();
    rst = 1'b1;
    sync();
    rst = 1'b0;
    @(negedge clk);
    check("rst_emit_valid", 32'(out_valid[0]), 32'd0);
    check("rst_emit_crc", 32'(crc[0]), 32'h6363);
    check("rst_emit_busy", 32'(busy[0]), 32'd0);
    check("rst_emit_out_data", 32'(out_data[0]), 32'h63);
    sync();

    // append_req together with an accepted byte is dropped (BITS_PER_CYCLE=8)
    do_start(3);
    in_valid[3]   = 1'b1;
    in_data[3]    = 8'h12;
    append_req[3] = 1'b1;
    @(negedge clk);
    check("drop_in_ready", 32'(in_ready[3]), 32'd1);
    sync();
    in_valid[3]   = 1'b0;
    append_req[3] = 1'b0;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      check($sformatf("drop_out_valid_%0d", t), 32'(out_valid[3]), 32'd0);
      check($sformatf("drop_busy_%0d", t), 32'(busy[3]), 32'd0);
      sync();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
